trng_entropy_reader: RTL and testbench

Consumer end of the TinyQV TRNG bit stream. It takes the sampled, XOR-combined ring-oscillator bit stream one bit per valid cycle and packs the bits into bytes. Two continuous SP 800-90B style health tests run on the stream: a repetition count test and an adaptive proportion test. Bytes that pass are buffered in a small FIFO that the TinyQV core reads through the standard peripheral register port; each read of the data register pops one byte.

---
 rtl/trng_entropy_reader.sv | 161 ++++++++++++++++
 tb/tb_trng_entropy_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/trng_entropy_reader.sv
// Packs the TRNG bit stream into bytes, runs repetition-count and adaptive-proportion
// health tests, and buffers passing bytes in a small FIFO behind the peripheral register port.
module trng_entropy_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 32,
  parameter int APT_WINDOW = 512,
  parameter int APT_CUTOFF = 410
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  input  logic       data_read,
  output logic [7:0] data_out,
  output logic       irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int PW = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;
  localparam int MW = $clog2(APT_CUTOFF + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_CUTOFF);
  localparam logic [PW-1:0] POS_LAST = PW'(APT_WINDOW - 1);
  localparam logic [MW-1:0] APT_MAX  = MW'(APT_CUTOFF);

  typedef enum logic [3:0] {
    ADDR_CTRL   = 4'h0,
    ADDR_STATUS = 4'h1,
    ADDR_DATA   = 4'h2
  } reg_addr_e;

  logic          enable, irq_en;
  logic          overflow, rct_fail, apt_fail;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt;
  logic          prev_bit;
  logic [RW-1:0] run_q;
  logic [PW-1:0] apt_pos;
  logic          apt_ref;
  logic [MW-1:0] match_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          ctrl_wr, clear_cmd, bit_take, byte_done;
  logic [7:0]    shift_nxt;
  logic [RW-1:0] run_nxt;
  logic [MW-1:0] match_nxt;
  logic          rct_trip, apt_trip, fail_now;
  logic          not_empty, full, pop, push, ovf_set;
  logic [3:0]    count_ext;
  logic [2:0]    level;

  always_comb begin
    ctrl_wr   = data_write && (address == ADDR_CTRL);
    clear_cmd = ctrl_wr && data_in[7];
    bit_take  = bit_valid && enable;
    shift_nxt = {bit_in, shift_q[7:1]};
    byte_done = bit_take && (bit_cnt == 3'd7);

    // run_q == 0 means no previous bit since reset, clear or enable rise.
    if (run_q == '0 || bit_in != prev_bit) run_nxt = RW'(1);
    else if (run_q == RCT_MAX)             run_nxt = run_q;
    else                                   run_nxt = run_q + RW'(1);

    if (apt_pos == '0)                              match_nxt = MW'(1);
    else if (bit_in == apt_ref && match_q != APT_MAX) match_nxt = match_q + MW'(1);
    else                                            match_nxt = match_q;

    rct_trip = bit_take && (run_nxt == RCT_MAX);
    apt_trip = bit_take && (match_nxt == APT_MAX);
    // A fail raised by the completing bit already blocks that byte.
    fail_now = rct_fail || apt_fail || rct_trip || apt_trip;

    not_empty = (count != '0);
    full      = (count == DEPTH_C);
    pop       = data_read && (address == ADDR_DATA) && not_empty;
    push      = byte_done && !fail_now && (!full || pop);
    ovf_set   = byte_done && !fail_now && full && !pop;

    count_ext = 4'(count);
    level     = (count_ext > 4'd7) ? 3'd7 : count_ext[2:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= data_in[0];
      irq_en <= data_in[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_cmd) begin
      overflow <= 1'b0;
      rct_fail <= 1'b0;
      apt_fail <= 1'b0;
      shift_q  <= '0;
      bit_cnt  <= '0;
      prev_bit <= 1'b0;
      run_q    <= '0;
      apt_pos  <= '0;
      apt_ref  <= 1'b0;
      match_q  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (!enable) begin
        bit_cnt <= '0;
        run_q   <= '0;
        apt_pos <= '0;
      end else if (bit_take) begin
        shift_q  <= shift_nxt;
        bit_cnt  <= bit_cnt + 3'd1;
        prev_bit <= bit_in;
        run_q    <= run_nxt;
        match_q  <= match_nxt;
        apt_pos  <= (apt_pos == POS_LAST) ? '0 : apt_pos + PW'(1);
        if (apt_pos == '0) apt_ref <= bit_in;
      end
      if (rct_trip) rct_fail <= 1'b1;
      if (apt_trip) apt_fail <= 1'b1;
      if (ovf_set)  overflow <= 1'b1;
      if (push)     wr_ptr   <= wr_ptr + AW'(1);
      if (pop)      rd_ptr   <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; entries are only visible through count, which is reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_nxt;
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL:   data_out = {6'b0, irq_en, enable};
      ADDR_STATUS: data_out = {level, apt_fail, rct_fail, overflow, full, not_empty};
      ADDR_DATA:   if (not_empty) data_out = mem[rd_ptr];
      default:     ;
    endcase
  end

  assign irq = irq_en && (not_empty || rct_fail || apt_fail);

endmodule

// File: tb/tb_trng_entropy_reader.sv
// Directed bench for trng_entropy_reader: register map, byte packing, FIFO,
// health tests and same-edge corner cases, with hand-computed expectations.
module tb_trng_entropy_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in, bit_valid;
  logic [3:0] address;
  logic       data_write, data_read;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] byte_in;
    logic [7:0] exp_status;
    logic [7:0] exp_pop;
  } fill_vec_t;

  fill_vec_t fill_vecs [5];

  trng_entropy_reader dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .address(address), .data_write(data_write), .data_in(data_in),
    .data_read(data_read), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] v);
    address = a; data_write = 1'b1; data_in = v;
    tick();
    data_write = 1'b0; data_in = 8'h00;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1 v = data_out;
  endtask

  task automatic pop_data(output logic [7:0] v);
    address = 4'h2; data_read = 1'b1;
    #1 v = data_out;
    tick();
    data_read = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_in = b; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic check_status(input string name, input logic [7:0] exp);
    logic [7:0] s;
    read_reg(4'h1, s);
    check(name, s, exp);
  endtask

  task automatic check_apt(input string name, input logic exp);
    logic [7:0] s;
    read_reg(4'h1, s);
    check(name, {7'b0, s[4]}, {7'b0, exp});
  endtask

  // One APT window with ones capped at 'cap'; 4:1 ones/zeros keeps runs short.
  task automatic feed_window(input int cap, input string name);
    int ones = 0;
    logic b;
    for (int i = 0; i < 512; i++) begin
      b = (ones < cap) && (i % 5 != 4);
      if (b) ones++;
      send_bit(b);
      if (i == 510) check_apt({name, "_before_last"}, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] v;

    fill_vecs[0] = '{8'h55, 8'h21, 8'h55};
    fill_vecs[1] = '{8'hAA, 8'h41, 8'hAA};
    fill_vecs[2] = '{8'h5A, 8'h61, 8'h5A};
    fill_vecs[3] = '{8'hA5, 8'h83, 8'hA5};
    fill_vecs[4] = '{8'h55, 8'h87, 8'h00};

    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; address = 4'h0;
    data_write = 1'b0; data_in = 8'h00; data_read = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 16; a++) begin
      read_reg(4'(a), v);
      check($sformatf("reset_addr_%0d", a), v, 8'h00);
    end
    check("reset_irq", {7'b0, irq}, 8'h00);

    // Gapped first byte: 1,0,1,1,0,0,1,0 -> 0x4D
    reg_write(4'h0, 8'h03);
    read_reg(4'h0, v);
    check("ctrl_readback", v, 8'h03);
    send_bit(1'b1); tick(); send_bit(1'b0); send_bit(1'b1); tick(); tick();
    send_bit(1'b1); send_bit(1'b0); tick(); send_bit(1'b0); send_bit(1'b1);
    check_status("seven_bits_empty", 8'h00);
    send_bit(1'b0);
    check_status("first_byte_status", 8'h21);
    read_reg(4'h2, v);
    check("first_byte_data", v, 8'h4D);
    check("first_byte_irq", {7'b0, irq}, 8'h01);
    pop_data(v);
    check("first_pop_data", v, 8'h4D);
    check_status("after_pop_status", 8'h00);
    check("after_pop_irq", {7'b0, irq}, 8'h00);

    // Fill past capacity, then drain in order
    for (int i = 0; i < 5; i++) begin
      send_bits(fill_vecs[i].byte_in, 8);
      check_status($sformatf("fill_status_%0d", i), fill_vecs[i].exp_status);
    end
    for (int i = 0; i < 5; i++) begin
      pop_data(v);
      check($sformatf("drain_data_%0d", i), v, fill_vecs[i].exp_pop);
    end
    check_status("drained_status", 8'h04);

    // RCT: 32 zeros, fourth byte blocked by the same bit that trips the test
    reg_write(4'h0, 8'h83);
    send_bits(8'h00, 8); send_bits(8'h00, 8); send_bits(8'h00, 8);
    send_bits(8'h00, 7);
    check_status("rct_31_bits", 8'h61);
    send_bit(1'b0);
    check_status("rct_32_bits", 8'h69);
    check("rct_irq", {7'b0, irq}, 8'h01);
    reg_write(4'h0, 8'h83);
    check_status("rct_cleared", 8'h00);
    read_reg(4'h0, v);
    check("clear_ctrl_readback", v, 8'h03);

    // APT: 409 matches passes and the window wraps; 410 matches fails on the last bit
    feed_window(409, "apt409");
    check_apt("apt409_end", 1'b0);
    send_bit(1'b1);
    check_apt("apt409_next_window", 1'b0);
    reg_write(4'h0, 8'h83);
    feed_window(410, "apt410");
    check_apt("apt410_end", 1'b1);
    reg_write(4'h0, 8'h83);
    check_status("apt_cleared", 8'h00);

    // Disable mid-byte discards the partial byte and ignores bits
    send_bits(8'hFF, 4);
    reg_write(4'h0, 8'h02);
    send_bits(8'h0F, 8);
    check_status("disabled_status", 8'h00);
    reg_write(4'h0, 8'h03);
    send_bits(8'hC3, 8);
    read_reg(4'h2, v);
    check("reenable_byte", v, 8'hC3);
    pop_data(v);

    // Full FIFO: completion and pop on the same edge
    send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8); send_bits(8'h44, 8);
    check_status("full_before", 8'h83);
    send_bits(8'h5C, 7);
    bit_in = 1'b0; bit_valid = 1'b1; address = 4'h2; data_read = 1'b1;
    #1 check("same_edge_pop_data", data_out, 8'h11);
    tick();
    bit_valid = 1'b0; data_read = 1'b0;
    check_status("same_edge_status", 8'h83);
    pop_data(v); check("same_edge_drain_0", v, 8'h22);
    pop_data(v); check("same_edge_drain_1", v, 8'h33);
    pop_data(v); check("same_edge_drain_2", v, 8'h44);
    pop_data(v); check("same_edge_drain_3", v, 8'h5C);
    check_status("same_edge_empty", 8'h00);

    // Clear command on the edge that completes a byte
    send_bits(8'h96, 7);
    bit_in = 1'b1; bit_valid = 1'b1; address = 4'h0; data_write = 1'b1; data_in = 8'h83;
    tick();
    bit_valid = 1'b0; data_write = 1'b0; data_in = 8'h00;
    check_status("clear_wins_status", 8'h00);

    // Reset mid-byte discards the partial byte
    send_bits(8'h07, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    read_reg(4'h0, v);
    check("midbyte_reset_ctrl", v, 8'h00);
    reg_write(4'h0, 8'h01);
    send_bits(8'h3C, 8);
    read_reg(4'h2, v);
    check("midbyte_reset_byte", v, 8'h3C);
    check("irq_disabled", {7'b0, irq}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
